// File: rtl/clb_param.sv
// Configurable logic block: NUM_BLE LUT_K-input LUTs with crossbar inputs and optional output
// registers, configured at runtime through a serial shift chain guarded by a load/verify FSM.
module clb_param #(
  parameter int LUT_K   = 4,
  parameter int NUM_IN  = 8,
  parameter int NUM_BLE = 2
) (
  input  logic               K,
  input  logic               RST_N,
  input  logic [NUM_IN-1:0]  I,
  input  logic               CE,
  input  logic               CFG_EN,
  input  logic               CFG_DI,
  output logic               CFG_DO,
  output logic [NUM_BLE-1:0] O,
  output logic               DONE,
  output logic               CFG_ERR
);

  localparam int NSRC    = NUM_IN + NUM_BLE;
  localparam int SEL_W   = $clog2(NSRC);
  localparam int SRC_W   = 1 << SEL_W;
  localparam int MASK_W  = 1 << LUT_K;
  localparam int BLE_W   = MASK_W + LUT_K * SEL_W + 2;
  localparam int CFG_LEN = NUM_BLE * BLE_W;
  localparam int CNT_W   = $clog2(CFG_LEN + 2);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CFG_LEN);

  typedef enum logic [1:0] {
    S_UNCONF = 2'd0,
    S_LOAD   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               err_nx;
  logic               q_init_ld;
  logic [CFG_LEN-1:0] cfg;
  logic [NUM_BLE-1:0] q;
  logic [NUM_BLE-1:0] f;
  logic [NUM_BLE-1:0] reg_mode;
  logic [NUM_BLE-1:0] qinit;
  logic [SRC_W-1:0]   src;

  // Crossbar source space: inputs, then register feedback, then constant-zero padding.
  always_comb begin
    src                   = '0;
    src[NUM_IN-1:0]       = I;
    src[NUM_IN +: NUM_BLE] = q;
  end

  for (genvar b = 0; b < NUM_BLE; b++) begin : g_ble
    localparam int BASE = b * BLE_W;
    logic [MASK_W-1:0] mask;
    logic [LUT_K-1:0]  addr;

    assign mask = cfg[BASE +: MASK_W];
    for (genvar j = 0; j < LUT_K; j++) begin : g_in
      assign addr[j] = src[cfg[BASE + MASK_W + j * SEL_W +: SEL_W]];
    end
    assign f[b]        = mask[addr];
    assign reg_mode[b] = cfg[BASE + BLE_W - 2];
    assign qinit[b]    = cfg[BASE + BLE_W - 1];
  end

  always_ff @(posedge K or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_UNCONF;
      cnt     <= '0;
      CFG_ERR <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      CFG_ERR <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    err_nx    = CFG_ERR;
    q_init_ld = 1'b0;
    case (state)
      S_UNCONF, S_ACTIVE: begin
        if (CFG_EN) begin
          state_nx = S_LOAD;
          cnt_nx   = CNT_W'(1);
        end
      end
      S_LOAD: begin
        if (CFG_EN) begin
          // Saturate one past full length so overlong loads stay detectable.
          if (cnt <= LEN_C) cnt_nx = cnt + CNT_W'(1);
        end else if (cnt == LEN_C) begin
          state_nx  = S_ACTIVE;
          err_nx    = 1'b0;
          q_init_ld = 1'b1;
        end else begin
          state_nx = S_UNCONF;
          err_nx   = 1'b1;
        end
      end
      default: state_nx = S_UNCONF;
    endcase
  end

  always_ff @(posedge K or negedge RST_N) begin
    if (!RST_N) begin
      cfg <= '0;
      q   <= '0;
    end else begin
      if (CFG_EN) cfg <= {CFG_DI, cfg[CFG_LEN-1:1]};
      if (q_init_ld) begin
        q <= qinit;
      end else if (state == S_ACTIVE && !CFG_EN && CE) begin
        q <= f;
      end
    end
  end

  assign DONE   = (state == S_ACTIVE);
  assign CFG_DO = cfg[0];
  assign O      = DONE ? ((reg_mode & q) | (~reg_mode & f)) : '0;

endmodule
